// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared state encoding and default width for the serial arithmetic blocks
package serial_arith_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/serial_subtractor_fs_bit.sv
// fs_bit: combinational full-subtractor cell, d = x - y - bi with borrow out
module fs_bit (
  output logic d,
  output logic bo,
  input  logic x,
  input  logic y,
  input  logic bi
);
  always_comb begin
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~x & bi) | (y & bi);
  end
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one bit per clock with a registered borrow
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
);
  localparam int CW = $clog2(WIDTH);
  state_t state;
  logic [WIDTH-1:0] sa, sb, sr;
  logic [CW-1:0] cnt;
  logic br, db, nb;
  fs_bit u_fs (.d(db), .bo(nb), .x(sa[0]), .y(sb[0]), .bi(br));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      d     <= '0;
      bo    <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sa    <= a;
          sb    <= b;
          sr    <= '0;
          br    <= 1'b0;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          br  <= nb;
          sr  <= {db, sr[WIDTH-1:1]};
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            d     <= {db, sr[WIDTH-1:1]};
            bo    <= nb;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor against a timeline model
module tb_serial_subtractor;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] a = '0, b = '0, d;
  logic busy, done, bo;
  int tests = 0, errs = 0;
  int m_age = 0;
  logic [W-1:0] m_d = '0, p_d = '0;
  logic m_bo = 1'b0, p_bo = 1'b0, ready = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .d(d), .bo(bo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: age counts edges since acceptance; result is plain unsigned subtraction
  always @(posedge clk) begin
    ready = 1'b1;
    if (rst) begin
      m_age = 0; m_d = '0; m_bo = 1'b0;
    end else if (m_age == 0) begin
      if (start) begin
        m_age = 1;
        p_d = a - b;
        p_bo = a < b;
      end
    end else if (m_age < W) m_age++;
    else if (m_age == W) begin
      m_age = W + 1; m_d = p_d; m_bo = p_bo;
    end else m_age = 0;
  end

  always @(negedge clk) if (ready) begin
    chk("busy", 32'(busy), 32'(m_age >= 1 && m_age <= W));
    chk("done", 32'(done), 32'(m_age == W + 1));
    chk("d", 32'(d), 32'(m_d));
    chk("bo", 32'(bo), 32'(m_bo));
  end

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] ed, input logic eb, input bit lit);
    int n;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(W + 1));
    if (lit) begin
      chk("lit_d", 32'(d), 32'(ed));
      chk("lit_bo", 32'(bo), 32'(eb));
    end
  endtask

  initial begin
    int dones;
    logic [W-1:0] x, y;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_bo", 32'(bo), 32'd0);
    rst = 1'b0;
    run_op(8'd100, 8'd58, 8'd42, 1'b0, 1'b1);
    run_op(8'd5, 8'd10, 8'hFB, 1'b1, 1'b1);
    run_op(8'd255, 8'd0, 8'hFF, 1'b0, 1'b1);
    run_op(8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    // start held high with operands churning during SHIFT/DONE
    @(negedge clk);
    a = 8'd200; b = 8'd1; start = 1'b1;
    dones = 0;
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom);
      if (done) dones++;
    end
    chk("hold_d", 32'(d), 32'd199);
    chk("hold_bo", 32'(bo), 32'd0);
    @(negedge clk);
    start = 1'b0;
    if (done) dones++;
    chk("hold_dones", 32'(dones), 32'd1);
    repeat (W + 3) @(negedge clk);
    // reset during the fourth busy cycle
    run_op(8'd20, 8'd7, 8'd13, 1'b0, 1'b1);
    @(negedge clk);
    a = 8'd9; b = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_d", 32'(d), 32'd0);
    chk("abort_bo", 32'(bo), 32'd0);
    run_op(8'd9, 8'd3, 8'd6, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      run_op(x, y, '0, 1'b0, 1'b0);
    end
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
